hex_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller on an Avalon-MM slave, successor to the single-digit 7-bit output port. Drives NUM_DIGITS displays from one register map. Per digit, the block selects hex-nibble decode or raw segments, blanking and blinking. Global controls are enable and leading-zero suppression. Sits on the lightweight HPS/soft-CPU bus and drives the board HEX pins directly.

---
 rtl/hex_display_pkg.sv | 41 ++++
 rtl/hex_display_ctrl_if.sv | 20 ++
 rtl/hex7seg_decode.sv | 9 +
 rtl/hex_display_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hex_display_pkg.sv
// Shared definitions for the multi-digit seven-segment display controller:
// register map, CTRL layout and the hex glyph table (bit 0 = seg a).
package hex_display_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_VALUE  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_BLANK  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_BLINK  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RAW_LO = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_RAW_HI = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd7;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_LZS_BIT = 1;

    typedef logic [SEG_W-1:0] seg_t;

    typedef struct packed {
        logic lzs;
        logic en;
    } ctrl_t;

    // Active-high glyphs 0-9, A, b, C, d, E, F
    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam seg_t SEG_ALL_OFF = 7'h00;

    function automatic seg_t seg_to_pins(input seg_t seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus of the display controller (read latency 0).
interface hex_display_ctrl_if
    import hex_display_pkg::*;
;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-high seven-segment glyph.
module hex7seg_decode
    import hex_display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output seg_t                seg_o
);
    assign seg_o = SEG_GLYPH[nibble_i];
endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: register file, blink generator,
// leading-zero suppression chain and a registered segment output.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    hex_display_ctrl_if.slave         bus,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out
);

    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam int HEX_W = SEG_W * NUM_DIGITS;
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
    localparam logic [HEX_W-1:0] HEX_OFF = {NUM_DIGITS{seg_to_pins(SEG_ALL_OFF, ACTIVE_LOW)}};

    logic [VAL_W-1:0]      value_q;
    logic [NUM_DIGITS-1:0] mode_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_DIGITS-1:0] blink_q;
    seg_t                  raw_q [NUM_DIGITS];
    ctrl_t                 ctrl_q;

    logic [31:0]           blink_cnt_q;
    logic                  blink_phase_q;

    logic [HEX_W-1:0]      hex_q;
    logic [HEX_W-1:0]      hex_d;

    logic [NUM_DIGITS-1:0] lzs_sup;
    logic                  lzs_scan;
    logic [DATA_W-1:0]     rd_data;

    logic wr_en;
    logic wr_blink;
    logic unused_wdata_bits;

    assign wr_en             = bus.chipselect && !bus.write_n;
    assign wr_blink          = wr_en && (bus.address == ADDR_BLINK);
    assign unused_wdata_bits = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            mode_q  <= '0;
            blank_q <= '0;
            blink_q <= '0;
            ctrl_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                raw_q[i] <= SEG_ALL_OFF;
            end
        end else if (wr_en) begin
            case (bus.address)
                ADDR_VALUE: value_q <= bus.writedata[VAL_W-1:0];
                ADDR_MODE:  mode_q  <= bus.writedata[NUM_DIGITS-1:0];
                ADDR_BLANK: blank_q <= bus.writedata[NUM_DIGITS-1:0];
                ADDR_BLINK: blink_q <= bus.writedata[NUM_DIGITS-1:0];
                // Each RAW word carries four digits, one byte each; bit 7 is dropped
                ADDR_RAW_LO: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (i < 4) raw_q[i] <= bus.writedata[8*(i%4) +: SEG_W];
                    end
                end
                ADDR_RAW_HI: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (i >= 4) raw_q[i] <= bus.writedata[8*(i%4) +: SEG_W];
                    end
                end
                ADDR_CTRL: begin
                    ctrl_q.en  <= bus.writedata[CTRL_EN_BIT];
                    ctrl_q.lzs <= bus.writedata[CTRL_LZS_BIT];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_VALUE: rd_data[VAL_W-1:0]      = value_q;
            ADDR_MODE:  rd_data[NUM_DIGITS-1:0] = mode_q;
            ADDR_BLANK: rd_data[NUM_DIGITS-1:0] = blank_q;
            ADDR_BLINK: rd_data[NUM_DIGITS-1:0] = blink_q;
            ADDR_RAW_LO: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i < 4) rd_data[8*(i%4) +: SEG_W] = raw_q[i];
                end
            end
            ADDR_RAW_HI: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i >= 4) rd_data[8*(i%4) +: SEG_W] = raw_q[i];
                end
            end
            ADDR_CTRL: begin
                rd_data[CTRL_EN_BIT]  = ctrl_q.en;
                rd_data[CTRL_LZS_BIT] = ctrl_q.lzs;
            end
            ADDR_STATUS: rd_data[0] = blink_phase_q;
            default: ;
        endcase
    end

    assign bus.readdata = rd_data;

    // A BLINK write restarts the half-period and takes priority over a wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (wr_blink) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 32'd1;
        end
    end

    // Suppress zero decode digits from the top; a raw digit or non-zero nibble ends the run
    always_comb begin
        lzs_sup  = '0;
        lzs_scan = ctrl_q.lzs;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lzs_scan && !mode_q[i] && (value_q[NIBBLE_W*i +: NIBBLE_W] == 4'h0)) begin
                lzs_sup[i] = 1'b1;
            end else begin
                lzs_scan = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg_t dec_seg;
        seg_t lit_seg;
        logic lit_on;

        hex7seg_decode u_decode (
            .nibble_i (value_q[NIBBLE_W*g +: NIBBLE_W]),
            .seg_o    (dec_seg)
        );

        assign lit_seg = mode_q[g] ? raw_q[g] : dec_seg;
        assign lit_on  = ctrl_q.en && !blank_q[g] && !lzs_sup[g]
                         && (!blink_q[g] || blink_phase_q);
        assign hex_d[SEG_W*g +: SEG_W] = seg_to_pins(lit_on ? lit_seg : SEG_ALL_OFF, ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q <= HEX_OFF;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex_out = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: a 6-digit and a 4-digit instance,
// stimulus pushes expectations tagged with a due cycle, a negedge monitor checks them.
module tb_hex_display_ctrl;
    import hex_display_pkg::*;

    typedef struct {
        int          due;
        int          dut;
        bit          is_rd;
        logic [63:0] exp;
        string       name;
    } exp_t;

    localparam logic [6:0] S0 = 7'h3F;
    localparam logic [6:0] S1 = 7'h06;
    localparam logic [6:0] S2 = 7'h5B;
    localparam logic [6:0] SC = 7'h39;
    localparam logic [6:0] SE = 7'h79;
    localparam logic [6:0] SF = 7'h71;
    localparam logic [6:0] SX = 7'h00;

    logic        clk;
    logic        reset_n;
    logic [41:0] hex6;
    logic [27:0] hex4;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    exp_t        sb_q[$];

    hex_display_ctrl_if bus6 ();
    hex_display_ctrl_if bus4 ();

    hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus6),
        .hex_out (hex6)
    );

    hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4),
        .hex_out (hex4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] p6(input logic [6:0] s5, s4, s3, s2, s1, s0);
        logic [41:0] pins;
        pins = ~{s5, s4, s3, s2, s1, s0};
        return 64'(pins);
    endfunction

    task automatic exp_hex(input int d, input int off, input logic [63:0] e, input string n);
        exp_t x;
        x.due = cyc + off; x.dut = d; x.is_rd = 1'b0; x.exp = e; x.name = n;
        sb_q.push_back(x);
    endtask

    task automatic exp_rd(input int d, input int off, input logic [63:0] e, input string n);
        exp_t x;
        x.due = cyc + off; x.dut = d; x.is_rd = 1'b1; x.exp = e; x.name = n;
        sb_q.push_back(x);
    endtask

    task automatic set_addr(input int d, input logic [2:0] a);
        if (d == 0) bus6.address = a;
        else        bus4.address = a;
    endtask

    task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
        if (d == 0) begin
            bus6.address = a; bus6.writedata = v; bus6.chipselect = 1'b1; bus6.write_n = 1'b0;
        end else begin
            bus4.address = a; bus4.writedata = v; bus4.chipselect = 1'b1; bus4.write_n = 1'b0;
        end
        @(posedge clk); #1;
        bus6.chipselect = 1'b0; bus6.write_n = 1'b1;
        bus4.chipselect = 1'b0; bus4.write_n = 1'b1;
    endtask

    task automatic rd_chk(input int d, input logic [2:0] a, input logic [31:0] e, input string n);
        set_addr(d, a);
        exp_rd(d, 0, 64'(e), n);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        int k;
        logic [63:0] act;
        k = 0;
        while (k < sb_q.size()) begin
            if (sb_q[k].due == cyc) begin
                if (sb_q[k].is_rd)
                    act = (sb_q[k].dut == 0) ? 64'(bus6.readdata) : 64'(bus4.readdata);
                else
                    act = (sb_q[k].dut == 0) ? 64'(hex6) : 64'(hex4);
                n_cmp++;
                if (act !== sb_q[k].exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", sb_q[k].name, act, sb_q[k].exp, cyc);
                end
                sb_q.delete(k);
            end else if (sb_q[k].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: not sampled, due cycle %0d now %0d", sb_q[k].name, sb_q[k].due, cyc);
                sb_q.delete(k);
            end else begin
                k++;
            end
        end
    end

    initial begin
        logic [63:0] on0;
        logic [63:0] off6;
        on0  = p6(SX, SX, SX, SX, SX, S0);
        off6 = 64'h3FF_FFFF_FFFF;
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        bus6.address = '0; bus6.chipselect = 1'b0; bus6.write_n = 1'b1; bus6.writedata = '0;
        bus4.address = '0; bus4.chipselect = 1'b0; bus4.write_n = 1'b1; bus4.writedata = '0;

        repeat (2) @(posedge clk);
        #1;
        exp_hex(0, 0, off6, "reset_hex6");
        exp_hex(1, 0, 64'h0FFF_FFFF, "reset_hex4");
        @(posedge clk); #1;
        reset_n = 1'b1;

        rd_chk(0, ADDR_STATUS, 32'h1, "reset_status");
        for (int a = 0; a < 7; a++) rd_chk(0, 3'(a), 32'h0, $sformatf("reset_reg%0d", a));

        // Hex decode and output latency
        wr(0, ADDR_VALUE, 32'h00C0_FFEE);
        wr(0, ADDR_CTRL, 32'h1);
        exp_hex(0, 0, off6, "decode_latency");
        exp_hex(0, 1, p6(SC, S0, SF, SF, SE, SE), "decode");
        rd_chk(0, ADDR_VALUE, 32'h00C0_FFEE, "value_readback");

        wr(0, ADDR_BLANK, 32'h2);
        exp_hex(0, 1, p6(SC, S0, SF, SF, SX, SE), "blank_digit1");
        wr(0, ADDR_BLANK, 32'h0);

        // Leading-zero suppression, stopped by a raw digit
        wr(0, ADDR_VALUE, 32'h0000_0012);
        wr(0, ADDR_CTRL, 32'h3);
        exp_hex(0, 1, p6(SX, SX, SX, SX, S1, S2), "lzs");
        wr(0, ADDR_MODE, 32'h20);
        exp_hex(0, 1, p6(SX, S0, S0, S0, S1, S2), "lzs_raw_stop");
        wr(0, ADDR_RAW_HI, 32'h0000_4000);
        exp_hex(0, 1, p6(7'h40, S0, S0, S0, S1, S2), "raw_seg_g");
        rd_chk(0, ADDR_RAW_HI, 32'h0000_4000, "raw_hi_readback");
        rd_chk(0, ADDR_MODE, 32'h20, "mode_readback");
        wr(0, ADDR_MODE, 32'h0);
        wr(0, ADDR_VALUE, 32'h0);
        exp_hex(0, 1, on0, "lzs_digit0_kept");

        // Blink on digit 0: 4 cycles on, 4 off
        wr(0, ADDR_BLINK, 32'h1);
        set_addr(0, ADDR_STATUS);
        for (int k = 0; k < 12; k++)
            exp_rd(0, k, ((k / 4) % 2 == 0) ? 64'h1 : 64'h0, $sformatf("blink_status%0d", k));
        for (int k = 1; k <= 12; k++)
            exp_hex(0, k, (((k - 1) / 4) % 2 == 0) ? on0 : off6, $sformatf("blink_hex%0d", k));
        repeat (12) @(posedge clk);
        #1;

        wr(0, ADDR_BLINK, 32'h1);
        exp_hex(0, 0, off6, "blink_rewrite_pre");
        exp_hex(0, 1, on0, "blink_rewrite");

        // BLINK write landing on the wrap edge
        repeat (3) @(posedge clk);
        #1;
        wr(0, ADDR_BLINK, 32'h1);
        set_addr(0, ADDR_STATUS);
        exp_rd(0, 0, 64'h1, "wrap_write_phase");
        exp_hex(0, 1, on0, "wrap_write_hex");
        exp_rd(0, 3, 64'h1, "wrap_write_phase3");
        exp_rd(0, 4, 64'h0, "wrap_write_phase4");
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset between edges
        wr(0, ADDR_BLINK, 32'h1);
        @(posedge clk); #1;
        exp_hex(0, 0, on0, "pre_reset_on");
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_hex(0, 0, off6, "async_reset_hex");
        @(posedge clk); #1;
        reset_n = 1'b1;
        set_addr(0, ADDR_STATUS);
        for (int k = 0; k < 5; k++)
            exp_rd(0, k, (k < 4) ? 64'h1 : 64'h0, $sformatf("post_reset_status%0d", k));
        exp_hex(0, 1, off6, "post_reset_hex");
        repeat (5) @(posedge clk);
        #1;
        rd_chk(0, ADDR_CTRL, 32'h0, "post_reset_ctrl");
        rd_chk(0, ADDR_BLINK, 32'h0, "post_reset_blink");

        // Width masking on the 4-digit instance
        wr(1, ADDR_VALUE, 32'hFFFF_FFFF);
        wr(1, ADDR_MODE, 32'hFFFF_FFFF);
        wr(1, ADDR_BLANK, 32'hFFFF_FFFF);
        wr(1, ADDR_RAW_HI, 32'hFFFF_FFFF);
        wr(1, ADDR_RAW_LO, 32'hFFFF_FFFF);
        rd_chk(1, ADDR_VALUE, 32'h0000_FFFF, "mask_value");
        rd_chk(1, ADDR_MODE, 32'h0000_000F, "mask_mode");
        rd_chk(1, ADDR_BLANK, 32'h0000_000F, "mask_blank");
        rd_chk(1, ADDR_RAW_HI, 32'h0000_0000, "mask_raw_hi");
        rd_chk(1, ADDR_RAW_LO, 32'h7F7F_7F7F, "mask_raw_lo");

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        while (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never sampled, due cycle %0d", sb_q[0].name, sb_q[0].due);
            void'(sb_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
